// File: rtl/core_block_ctrl.sv
// -----------------------------------------------------------------------------
// core_block_ctrl
//
// Core-side end of the block dispatch handshake. Latches a block launched by
// the dispatcher, then steps each instruction through
// FETCH -> DECODE -> (REQUEST -> WAIT) -> EXECUTE -> UPDATE until a RET
// retires. core_done is then held until the dispatcher pulses core_reset.
//
// Optional feature (macro CORE_WATCHDOG_EN):
//   A 16-bit cycle counter aborts a FETCH or WAIT that lasts WDT_CYCLES
//   cycles. The abort ends in DONE with err=1. Without the macro, no counter
//   is built, err is tied low, and FETCH/WAIT wait forever.
//
// Parameters:
//   THREADS_PER_BLOCK  threads per block (power of two, >= 1)
//   PC_WIDTH           program counter width
//   WDT_CYCLES         watchdog limit in cycles (watchdog build only)
//
// Ports:
//   clk, reset            clock (rising edge); async active-low global reset
//   core_reset            sync active-high soft reset from the dispatcher
//   core_start            block launch request (only honoured in IDLE)
//   core_block_id         block index, sampled on launch
//   core_thread_count     active thread count, sampled on launch
//   core_done             block finished, held until core_reset
//   block_id              latched block index
//   thread_enable         per-thread active mask
//   pc                    current program counter
//   fetch_req             instruction fetch request
//   fetch_ready           fetched instruction valid (with instr_ret/instr_mem)
//   instr_ret, instr_mem  fetched instruction is RET / is a load-store
//   lsu_req               one-cycle LSU launch pulse
//   lsu_busy              per-thread LSU busy
//   branch_taken          take branch_target in UPDATE
//   branch_target         branch destination
//   exec_en               one-cycle ALU / register-file write pulse
//   err                   watchdog abort flag
// -----------------------------------------------------------------------------
module core_block_ctrl #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8,
  parameter int WDT_CYCLES        = 255
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                core_reset,
  input  logic                                core_start,
  input  logic [7:0]                          core_block_id,
  input  logic [$clog2(THREADS_PER_BLOCK):0]  core_thread_count,
  output logic                                core_done,
  output logic [7:0]                          block_id,
  output logic [THREADS_PER_BLOCK-1:0]        thread_enable,
  output logic [PC_WIDTH-1:0]                 pc,
  output logic                                fetch_req,
  input  logic                                fetch_ready,
  input  logic                                instr_ret,
  input  logic                                instr_mem,
  output logic                                lsu_req,
  input  logic [THREADS_PER_BLOCK-1:0]        lsu_busy,
  input  logic                                branch_taken,
  input  logic [PC_WIDTH-1:0]                 branch_target,
  output logic                                exec_en,
  output logic                                err
);

  localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQUEST,
    S_WAIT,
    S_EXECUTE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic                         instr_ret_q;
  logic                         instr_mem_q;
  logic [THREADS_PER_BLOCK-1:0] launch_mask;
  logic                         wdt_hit;

  // Thread i is active when i < core_thread_count. Counts above
  // THREADS_PER_BLOCK therefore saturate to an all-ones mask.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    launch_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      launch_mask[i] = (core_thread_count > CNT_W'(i));
    end
  end

  // Next-state logic. Outputs are registered from state_nxt below, so each
  // output rises in the first cycle of its state, with no path from an input.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (core_start) begin
          state_nxt = (core_thread_count == '0) ? S_DONE : S_FETCH;
        end
      S_FETCH:
        if (fetch_ready) begin
          state_nxt = S_DECODE;
        end else if (wdt_hit) begin
          state_nxt = S_DONE;
        end
      S_DECODE:
        state_nxt = instr_mem_q ? S_REQUEST : S_EXECUTE;
      S_REQUEST:
        state_nxt = S_WAIT;
      S_WAIT:
        // Busy bits of disabled threads are masked off.
        if ((lsu_busy & thread_enable) == '0) begin
          state_nxt = S_EXECUTE;
        end else if (wdt_hit) begin
          state_nxt = S_DONE;
        end
      S_EXECUTE:
        state_nxt = instr_ret_q ? S_DONE : S_UPDATE;
      S_UPDATE:
        state_nxt = S_FETCH;
      S_DONE:
        state_nxt = S_DONE;
    endcase
    // A soft reset wins over everything, including a same-cycle core_start.
    if (core_reset) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      fetch_req     <= 1'b0;
      lsu_req       <= 1'b0;
      exec_en       <= 1'b0;
      core_done     <= 1'b0;
      block_id      <= '0;
      thread_enable <= '0;
      pc            <= '0;
      instr_ret_q   <= 1'b0;
      instr_mem_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register here samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      fetch_req <= (state_nxt == S_FETCH);
      lsu_req   <= (state_nxt == S_REQUEST);
      exec_en   <= (state_nxt == S_EXECUTE);
      core_done <= (state_nxt == S_DONE);

      if (core_reset) begin
        block_id      <= '0;
        thread_enable <= '0;
        pc            <= '0;
        instr_ret_q   <= 1'b0;
        instr_mem_q   <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (core_start) begin
              block_id      <= core_block_id;
              thread_enable <= launch_mask;
              pc            <= '0;
            end
          S_FETCH:
            if (fetch_ready) begin
              instr_ret_q <= instr_ret;
              instr_mem_q <= instr_mem;
            end
          S_UPDATE:
            // The increment wraps modulo 2^PC_WIDTH.
            pc <= branch_taken ? branch_target : pc + PC_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef CORE_WATCHDOG_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

  logic [15:0] wdt_cnt;

  // The counter restarts on every state change, so its value is the number
  // of cycles already spent in the current FETCH or WAIT. The cycle in which
  // it reads WDT_LAST is the WDT_CYCLES-th one, which triggers the abort.
  assign wdt_hit = (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt <= '0;
      err     <= 1'b0;
    end else if (core_reset) begin
      wdt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        wdt_cnt <= '0;
      end else if (state == S_FETCH || state == S_WAIT) begin
        wdt_cnt <= wdt_cnt + 16'd1;
      end
      // FETCH/WAIT reach DONE only through a watchdog abort.
      if (state_nxt == S_DONE && (state == S_FETCH || state == S_WAIT)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign wdt_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_core_block_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_block_ctrl
//
// Self-checking bench for core_block_ctrl (THREADS_PER_BLOCK=4, PC_WIDTH=8).
// A small instruction memory indexed by the DUT's pc supplies instr_ret,
// instr_mem, branch_taken and branch_target. Each test pushes the program
// counters it expects to be fetched onto a queue. A negedge monitor pops one
// entry per fetch handshake and compares it with pc. The monitor also counts
// the exec_en and lsu_req pulses. Define CORE_WATCHDOG_EN to build the
// watchdog variant, which uses WDT_CYCLES=10.
// -----------------------------------------------------------------------------
module tb_core_block_ctrl;

  localparam int TPB = 4;
  localparam int PCW = 8;
`ifdef CORE_WATCHDOG_EN
  localparam int WDT = 10;
`else
  localparam int WDT = 255;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           core_reset;
  logic           core_start;
  logic [7:0]     core_block_id;
  logic [2:0]     core_thread_count;
  logic           core_done;
  logic [7:0]     block_id;
  logic [TPB-1:0] thread_enable;
  logic [PCW-1:0] pc;
  logic           fetch_req;
  logic           fetch_ready;
  logic           instr_ret;
  logic           instr_mem;
  logic           lsu_req;
  logic [TPB-1:0] lsu_busy;
  logic           branch_taken;
  logic [PCW-1:0] branch_target;
  logic           exec_en;
  logic           err;

  // Instruction memory, read combinationally at the DUT's pc.
  logic           imem_ret [0:255];
  logic           imem_mem [0:255];
  logic           imem_br  [0:255];
  logic [7:0]     imem_tgt [0:255];

  assign instr_ret     = imem_ret[pc];
  assign instr_mem     = imem_mem[pc];
  assign branch_taken  = imem_br[pc];
  assign branch_target = imem_tgt[pc];

  logic [7:0] fetch_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_exec  = 0;
  int n_lsu   = 0;

  core_block_ctrl #(
    .THREADS_PER_BLOCK (TPB),
    .PC_WIDTH          (PCW),
    .WDT_CYCLES        (WDT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .core_reset        (core_reset),
    .core_start        (core_start),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .core_done         (core_done),
    .block_id          (block_id),
    .thread_enable     (thread_enable),
    .pc                (pc),
    .fetch_req         (fetch_req),
    .fetch_ready       (fetch_ready),
    .instr_ret         (instr_ret),
    .instr_mem         (instr_mem),
    .lsu_req           (lsu_req),
    .lsu_busy          (lsu_busy),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .exec_en           (exec_en),
    .err               (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer and pulse counters.
  always @(negedge clk) begin
    if (reset) begin
      if (exec_en) n_exec++;
      if (lsu_req) n_lsu++;
      if (exec_en || lsu_req) check("pulse_excl", 32'(exec_en & lsu_req), 32'(0));
      if (fetch_req && fetch_ready) begin
        if (fetch_q.size() > 0) check("fetch_pc", 32'(pc), 32'(fetch_q.pop_front()));
        else                    check("fetch_extra", 32'(pc), 32'hDEAD);
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) begin
      imem_ret[i] = 1'b0;
      imem_mem[i] = 1'b0;
      imem_br[i]  = 1'b0;
      imem_tgt[i] = 8'h00;
    end
  endtask

  // Called at a negedge; returns at the negedge after the launch edge.
  task automatic launch(input logic [7:0] id, input logic [2:0] cnt);
    core_block_id     = id;
    core_thread_count = cnt;
    core_start        = 1'b1;
    @(negedge clk);
    core_start        = 1'b0;
  endtask

  task automatic soft_reset();
    core_reset = 1'b1;
    @(negedge clk);
    core_reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (!core_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(core_done), 32'(1));
  endtask

  initial begin : main
    int         cyc;
    int         e0;
    int         l0;
    int         nf;
    logic [7:0] prev;

    reset = 1'b0; core_reset = 1'b0; core_start = 1'b0;
    core_block_id = 8'h00; core_thread_count = 3'd0;
    fetch_ready = 1'b0; lsu_busy = '0;
    clear_imem();
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({core_done, block_id, thread_enable, pc, fetch_req, lsu_req, exec_en, err}), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // ALU program: two plain instructions, then RET at pc 2.
    fetch_ready = 1'b1;
    imem_ret[2] = 1'b1;
    fetch_q.push_back(8'd0); fetch_q.push_back(8'd1); fetch_q.push_back(8'd2);
    e0 = n_exec; l0 = n_lsu;
    launch(8'd1, 3'd2);
    check("alu_fetch_req", 32'(fetch_req), 32'(1));
    wait_done("alu_done", 50, cyc);
    check("alu_done_cycles", 32'(cyc), 32'(11));
    check("alu_thread_en", 32'(thread_enable), 32'(4'b0011));
    check("alu_block_id", 32'(block_id), 32'(1));
    check("alu_pc", 32'(pc), 32'(2));
    check("alu_exec_pulses", 32'(n_exec - e0), 32'(3));
    check("alu_lsu_pulses", 32'(n_lsu - l0), 32'(0));
    check("alu_fetch_left", 32'(fetch_q.size()), 32'(0));

    // Dispatcher handshake: start ignored in DONE; reset beats start.
    core_block_id = 8'd9; core_thread_count = 3'd4; core_start = 1'b1;
    @(negedge clk);
    core_start = 1'b0;
    check("done_start_ignored", 32'({core_done, fetch_req}), 32'(2'b10));
    check("done_block_kept", 32'(block_id), 32'(1));
    core_reset = 1'b1; core_start = 1'b1;
    @(negedge clk);
    core_reset = 1'b0; core_start = 1'b0;
    check("softrst_clear", 32'({core_done, block_id, thread_enable, pc}), 32'(0));
    @(negedge clk);
    check("softrst_no_start", 32'(fetch_req), 32'(0));

    // Memory wait with masking: only threads 0..1 enabled.
    clear_imem();
    imem_mem[0] = 1'b1;
    imem_ret[1] = 1'b1;
    lsu_busy = 4'b1101;
    fetch_q.push_back(8'd0); fetch_q.push_back(8'd1);
    e0 = n_exec; l0 = n_lsu;
    launch(8'd2, 3'd2);
    cyc = 0;
    while (!lsu_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("mem_lsu_req", 32'(lsu_req), 32'(1));
    repeat (3) @(negedge clk);
    check("mem_wait_hold", 32'({exec_en, lsu_req}), 32'(0));
    lsu_busy = 4'b1100;
    @(negedge clk);
    check("mem_wait_exit", 32'(exec_en), 32'(1));
    wait_done("mem_done", 50, cyc);
    check("mem_lsu_pulses", 32'(n_lsu - l0), 32'(1));
    check("mem_exec_pulses", 32'(n_exec - e0), 32'(2));
    check("mem_pc", 32'(pc), 32'(1));
    check("mem_fetch_left", 32'(fetch_q.size()), 32'(0));
    soft_reset();
    lsu_busy = '0;

    // Branch to 0xFF, then the increment wraps to 0x00.
    clear_imem();
    imem_br[0] = 1'b1;
    imem_tgt[0] = 8'hFF;
    fetch_q.push_back(8'h00); fetch_q.push_back(8'hFF); fetch_q.push_back(8'h00);
    launch(8'd3, 3'd4);
    prev = pc; cyc = 0;
    while (pc != 8'hFF && cyc < 20) begin
      prev = pc;
      @(negedge clk);
      cyc++;
    end
    check("br_target_pc", 32'(pc), 32'hFF);
    check("br_prev_pc", 32'(prev), 32'(0));
    imem_br[0]  = 1'b0;
    imem_ret[0] = 1'b1;
    wait_done("br_done", 50, cyc);
    check("br_wrap_pc", 32'(pc), 32'(0));
    check("br_fetch_left", 32'(fetch_q.size()), 32'(0));
    soft_reset();

    // Zero thread count: straight to DONE, no fetch.
    clear_imem();
    imem_ret[0] = 1'b1;
    launch(8'd4, 3'd0);
    check("zero_done", 32'({core_done, fetch_req}), 32'(2'b10));
    check("zero_thread_en", 32'(thread_enable), 32'(0));
    repeat (2) @(negedge clk);
    soft_reset();

    // Oversize thread count saturates the mask.
    fetch_q.push_back(8'd0);
    launch(8'd5, 3'd7);
    check("over_thread_en", 32'(thread_enable), 32'(4'b1111));
    check("over_fetch_req", 32'(fetch_req), 32'(1));
    wait_done("over_done", 50, cyc);
    soft_reset();

    // Fetch never answered.
    fetch_ready = 1'b0;
    launch(8'd6, 3'd4);
`ifdef CORE_WATCHDOG_EN
    cyc = 0; nf = 0;
    while (!core_done && cyc < 40) begin
      if (fetch_req) nf++;
      @(negedge clk);
      cyc++;
    end
    check("wdt_fetch_cycles", 32'(nf), 32'(10));
    check("wdt_done_err", 32'({core_done, err}), 32'(2'b11));
    soft_reset();
    check("wdt_err_cleared", 32'({core_done, err}), 32'(0));
    fetch_ready = 1'b1;
`else
    nf = 0;
    repeat (20) begin
      if (fetch_req) nf++;
      @(negedge clk);
    end
    check("nowdt_fetch_held", 32'(nf), 32'(20));
    check("nowdt_no_abort", 32'({core_done, err, fetch_req}), 32'(3'b001));
    fetch_q.push_back(8'd0);
    fetch_ready = 1'b1;
    wait_done("nowdt_done", 20, cyc);
    soft_reset();
`endif

    // Asynchronous reset in the middle of WAIT.
    clear_imem();
    imem_mem[0] = 1'b1;
    imem_ret[0] = 1'b1;
    lsu_busy = 4'b0001;
    fetch_q.push_back(8'd0);
    launch(8'd6, 3'd1);
    cyc = 0;
    while (!lsu_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("midwait_block_id", 32'(block_id), 32'(6));
    #2 reset = 1'b0;
    #1 check("async_reset_outs",
             32'({core_done, block_id, thread_enable, pc, fetch_req, lsu_req, exec_en, err}), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    lsu_busy = '0;
    fetch_q.push_back(8'd0);
    launch(8'd7, 3'd1);
    check("relaunch_fetch_req", 32'(fetch_req), 32'(1));
    wait_done("relaunch_done", 50, cyc);
    check("relaunch_fetch_left", 32'(fetch_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_block_ctrl.md
# core_block_ctrl

Per-core block execution controller: the core-side end of the block dispatch handshake. It accepts `core_start`, `core_block_id` and `core_thread_count` from the dispatcher and latches the block. It then sequences every instruction of the block through fetch / decode / memory-wait / execute / PC-update, and holds `core_done` until the dispatcher pulses `core_reset`. One instance sits in each compute core, between the dispatcher and the core's fetcher, LSUs and ALUs.

## Interface
- `THREADS_PER_BLOCK`, 4, threads per block; must be a power of two, ≥1
- `PC_WIDTH`, 8, program counter width
- `WDT_CYCLES`, 255, watchdog limit in cycles (used only with `CORE_WATCHDOG_EN`)
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low global reset
- `core_reset` in 1: synchronous active-high soft reset from the dispatcher
- `core_start` in 1: block launch request from the dispatcher
- `core_block_id` in 8: block index, sampled on launch
- `core_thread_count` in $clog2(THREADS_PER_BLOCK)+1: active threads, sampled on launch
- `core_done` out 1: block finished; held high until `core_reset`
- `block_id` out 8: latched block index
- `thread_enable` out THREADS_PER_BLOCK: per-thread active mask
- `pc` out PC_WIDTH: current program counter
- `fetch_req` out 1: instruction fetch request
- `fetch_ready` in 1: instruction available; `instr_ret` and `instr_mem` are valid in the same cycle
- `instr_ret` in 1: the fetched instruction is RET
- `instr_mem` in 1: the fetched instruction is a load or store
- `lsu_req` out 1: one-cycle LSU launch pulse
- `lsu_busy` in THREADS_PER_BLOCK: per-thread LSU busy
- `branch_taken`, `branch_target` in 1 / PC_WIDTH: PC-update inputs, sampled in UPDATE
- `exec_en` out 1: one-cycle ALU/register-file write pulse
- `err` out 1: watchdog abort flag

## Operation
- States: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
- IDLE → FETCH on `core_start`. In the same edge, latch:
  - `block_id` = `core_block_id`
  - `thread_enable` = (1<<n)−1, where n = min(`core_thread_count`, THREADS_PER_BLOCK)
  - `pc` = 0
- If n = 0, the next state is DONE instead of FETCH. No fetch is issued.
- FETCH: `fetch_req`=1 until `fetch_ready`. On `fetch_ready`, latch `instr_ret`/`instr_mem` and go to DECODE.
- DECODE (1 cycle) → REQUEST if `instr_mem`, else → EXECUTE.
- REQUEST: `lsu_req`=1 for exactly one cycle → WAIT.
- WAIT: stay while (`lsu_busy` & `thread_enable`) ≠ 0. Busy bits of disabled threads are ignored. Leave for EXECUTE when the masked busy is 0.
- EXECUTE: `exec_en`=1 for one cycle. → DONE if the latched `instr_ret`, else → UPDATE.
- UPDATE: `pc` ← `branch_taken` ? `branch_target` : `pc`+1 (modulo 2^PC_WIDTH, wraps 255→0) → FETCH.
- DONE: `core_done`=1. Stays in DONE until `core_reset`.
- `core_start` is ignored in every state except IDLE.
- `core_reset` (any state) → IDLE on the next edge. It clears `core_done`, `err`, `thread_enable`, `pc`, `block_id`. It has priority over `core_start` in the same cycle.
- `reset` low: asynchronous return to IDLE, all registers cleared, mid-instruction included.

## Timing
- Reset values: all outputs 0; state IDLE.
- All outputs are registered or decoded from state only. No input→output combinational path.
- Launch: `core_start` sampled at edge E → FETCH from E; `fetch_req` high in the cycle after E.
- Non-memory instruction with `fetch_ready` already high: 4 cycles (FETCH, DECODE, EXECUTE, UPDATE).
- Memory instruction with the LSU idle one cycle after `lsu_req`: 6 cycles.
- RET: `core_done` rises at the edge ending the EXECUTE cycle. No UPDATE follows, so `pc` holds the RET address.
- `exec_en` and `lsu_req` are never high in the same cycle. Each is at most one cycle per instruction.

## Configuration
- `CORE_WATCHDOG_EN` defined:
  - A 16-bit counter clears on every state change and counts cycles spent in FETCH or WAIT.
  - When it reaches `WDT_CYCLES`, go to DONE with `err`=1 and `core_done`=1.
  - `err` is cleared only by `core_reset`/`reset`.
- Not defined:
  - No counter is built; `err` is tied to 0.
  - FETCH and WAIT wait indefinitely.

## Test plan
- Reset mid-WAIT: drive `reset` low during WAIT → all outputs 0 immediately (asynchronous). Release, then `core_start` → `fetch_req` high one cycle later.
- Launch and ALU program: `core_block_id`=1, `core_thread_count`=2, `fetch_ready` tied 1, two non-RET instructions then RET → `thread_enable`=4'b0011, `block_id`=1, `exec_en` pulses 3 times, `core_done` rises 11 cycles after the launch edge, `pc`=2.
- Memory wait with masking: `core_thread_count`=2, `instr_mem`=1, `lsu_busy`=4'b1100 held, then 4'b0001 for 3 cycles → WAIT ignores bits 3:2 and exits 1 cycle after bit 0 drops; `lsu_req` is a single pulse.
- Branch and wrap: `branch_taken`=1, `branch_target`=8'hFF, next instruction non-branch → `pc` goes 0→FF→00.
- Zero/oversize count: `core_thread_count`=0 → `core_done` one cycle after launch with no `fetch_req`. `core_thread_count`=7 (with THREADS_PER_BLOCK=4) → `thread_enable`=4'b1111.
- Dispatcher handshake and watchdog: in DONE, `core_start`=1 → ignored; `core_reset` and `core_start` in the same cycle → IDLE, `core_done`=0. With `CORE_WATCHDOG_EN` and `WDT_CYCLES`=10, `fetch_ready` held 0 → `err`=1 and `core_done`=1 after 10 FETCH cycles.
